gray_pos_tracker: RTL and testbench

//  Consumes the 3-bit Gray code (G,H,I) produced by the binary-to-Gray stage.

---
 rtl/gray_pkg.sv | 17 +
 rtl/gray_pos_tracker_if.sv | 27 ++
 rtl/gray2bin3_dec.sv | 9 +
 rtl/gray_pos_tracker.sv | 161 ++++++++++++++++
 tb/tb_gray_pos_tracker.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code position tracker.
package gray_pkg;

  localparam int GRAY_W = 3;
  localparam logic [GRAY_W-1:0] DELTA_UP = 3'd1;
  localparam logic [GRAY_W-1:0] DELTA_DN = 3'd7;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } trk_state_t;

  function automatic logic [GRAY_W-1:0] gray2bin3(input logic [GRAY_W-1:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/gray_pos_tracker_if.sv
// Sample input and tracking-status bundle between the Gray source and the tracker.
interface gray_pos_tracker_if
  import gray_pkg::*;
#(
  parameter int WRAP_W = 8
);
  logic              G;
  logic              H;
  logic              I;
  logic              in_valid;
  logic [GRAY_W-1:0] bin;
  logic              out_valid;
  logic              dir_up;
  logic              step_err;
  logic              locked;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output G, H, I, in_valid,
    input  bin, out_valid, dir_up, step_err, locked, wrap_cnt
  );

  modport slave (
    input  G, H, I, in_valid,
    output bin, out_valid, dir_up, step_err, locked, wrap_cnt
  );
endinterface

// File: rtl/gray2bin3_dec.sv
// Combinational 3-bit Gray-to-binary decoder.
module gray2bin3_dec
  import gray_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [GRAY_W-1:0] bin
);
  assign bin = gray2bin3(gray);
endmodule

// File: rtl/gray_pos_tracker.sv
// Registers Gray samples, decodes them and tracks direction, revolutions and lock.
module gray_pos_tracker
  import gray_pkg::*;
#(
  parameter int WRAP_W    = 8,
  parameter int LOCK_N    = 2,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  gray_pos_tracker_if.slave bus
);
  localparam int STB_W = (LOCK_N < 2) ? 2 : $clog2(LOCK_N + 1);
  localparam int ERR_W = (ERR_LIMIT < 2) ? 2 : $clog2(ERR_LIMIT + 1);

  trk_state_t        state_r, state_nx_s;
  logic [STB_W-1:0]  stable_r, stable_nx_s;
  logic [ERR_W-1:0]  err_r, err_nx_s;
  logic              seeded_r, seeded_nx_s;
  logic [GRAY_W-1:0] bin_r, bin_nx_s, bin_dec_s, delta_s;
  logic              out_valid_r, out_valid_nx_s;
  logic              dir_up_r, dir_up_nx_s;
  logic              step_err_r, step_err_nx_s;
  logic [WRAP_W-1:0] wrap_r, wrap_nx_s;
  logic              legal_s;

  gray2bin3_dec u_dec (
    .gray ({bus.G, bus.H, bus.I}),
    .bin  (bin_dec_s)
  );

  // bin_r doubles as the previous position once a seed has been taken
  assign delta_s = bin_dec_s - bin_r;
  assign legal_s = (delta_s == 3'd0) || (delta_s == DELTA_UP) || (delta_s == DELTA_DN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACQUIRE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and lock/error counter logic
  always_comb begin
    state_nx_s  = state_r;
    stable_nx_s = stable_r;
    err_nx_s    = err_r;
    seeded_nx_s = seeded_r;
    if (bus.in_valid) begin
      seeded_nx_s = 1'b1;
      case (state_r)
        ACQUIRE: begin
          if (!seeded_r || !legal_s) begin
            stable_nx_s = STB_W'(1);
          end else begin
            stable_nx_s = stable_r + STB_W'(1);
          end
          if (stable_nx_s == STB_W'(LOCK_N)) begin
            state_nx_s = LOCKED;
            err_nx_s   = {ERR_W{1'b0}};
          end else begin
            state_nx_s = ACQUIRE;
          end
        end
        LOCKED: begin
          if (legal_s) begin
            err_nx_s = {ERR_W{1'b0}};
          end else if (err_r + ERR_W'(1) == ERR_W'(ERR_LIMIT)) begin
            // Too many bad steps: the offending sample becomes the new seed
            state_nx_s  = ACQUIRE;
            stable_nx_s = STB_W'(1);
            err_nx_s    = {ERR_W{1'b0}};
          end else begin
            err_nx_s = err_r + ERR_W'(1);
          end
        end
        default: begin
          state_nx_s = ACQUIRE;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Output next values: direction and revolutions only move while LOCKED
  always_comb begin
    bin_nx_s       = bin_r;
    out_valid_nx_s = 1'b0;
    dir_up_nx_s    = dir_up_r;
    step_err_nx_s  = 1'b0;
    wrap_nx_s      = wrap_r;
    if (bus.in_valid) begin
      bin_nx_s       = bin_dec_s;
      out_valid_nx_s = 1'b1;
      if (state_r == LOCKED) begin
        case (delta_s)
          3'd0: begin
            dir_up_nx_s = dir_up_r;
          end
          DELTA_UP: begin
            dir_up_nx_s = 1'b1;
            if (bin_r == 3'd7) begin
              wrap_nx_s = wrap_r + WRAP_W'(1);
            end else begin
              wrap_nx_s = wrap_r;
            end
          end
          DELTA_DN: begin
            dir_up_nx_s = 1'b0;
            if (bin_r == 3'd0) begin
              wrap_nx_s = wrap_r - WRAP_W'(1);
            end else begin
              wrap_nx_s = wrap_r;
            end
          end
          default: begin
            step_err_nx_s = 1'b1;
          end
        endcase
      end else begin
        dir_up_nx_s = dir_up_r;
      end
    end else begin
      bin_nx_s = bin_r;
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_r    <= {STB_W{1'b0}};
      err_r       <= {ERR_W{1'b0}};
      seeded_r    <= 1'b0;
      bin_r       <= {GRAY_W{1'b0}};
      out_valid_r <= 1'b0;
      dir_up_r    <= 1'b0;
      step_err_r  <= 1'b0;
      wrap_r      <= {WRAP_W{1'b0}};
    end else begin
      stable_r    <= stable_nx_s;
      err_r       <= err_nx_s;
      seeded_r    <= seeded_nx_s;
      bin_r       <= bin_nx_s;
      out_valid_r <= out_valid_nx_s;
      dir_up_r    <= dir_up_nx_s;
      step_err_r  <= step_err_nx_s;
      wrap_r      <= wrap_nx_s;
    end
  end

  assign bus.bin       = bin_r;
  assign bus.out_valid = out_valid_r;
  assign bus.dir_up    = dir_up_r;
  assign bus.step_err  = step_err_r;
  assign bus.locked    = (state_r == LOCKED);
  assign bus.wrap_cnt  = wrap_r;

endmodule

// File: tb/tb_gray_pos_tracker.sv
// Directed bench for gray_pos_tracker with a per-cycle reference model.
module tb_gray_pos_tracker;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  // Reference model state (integers, cyclic arithmetic)
  int m_bin, m_ov, m_dir, m_serr, m_locked, m_wrap;
  int m_seeded, m_stable, m_err;

  logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  gray_pos_tracker_if #(.WRAP_W(8)) bus ();

  gray_pos_tracker #(.WRAP_W(8), .LOCK_N(2), .ERR_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_update(input int g, input bit v, input bit r);
    int nb, d;
    if (r) begin
      m_bin = 0; m_ov = 0; m_dir = 0; m_serr = 0; m_locked = 0; m_wrap = 0;
      m_seeded = 0; m_stable = 0; m_err = 0;
    end else if (v) begin
      nb = g ^ (g >> 1) ^ (g >> 2);
      d = (nb - m_bin + 8) % 8;
      m_ov = 1;
      m_serr = 0;
      if (m_locked == 0) begin
        if (m_seeded == 0 || !(d == 0 || d == 1 || d == 7)) m_stable = 1;
        else m_stable = m_stable + 1;
        m_seeded = 1;
        if (m_stable >= 2) begin
          m_locked = 1;
          m_err = 0;
        end
      end else begin
        if (d == 1) begin
          m_dir = 1; m_err = 0;
          if (m_bin == 7) m_wrap = (m_wrap + 1) % 256;
        end else if (d == 7) begin
          m_dir = 0; m_err = 0;
          if (m_bin == 0) m_wrap = (m_wrap + 255) % 256;
        end else if (d == 0) begin
          m_err = 0;
        end else begin
          m_serr = 1;
          m_err = m_err + 1;
          if (m_err == 3) begin
            m_locked = 0; m_stable = 1; m_err = 0;
          end
        end
      end
      m_bin = nb;
    end else begin
      m_ov = 0;
      m_serr = 0;
    end
  endtask

  task automatic check_all();
    chk("bin",       int'(bus.bin),       m_bin);
    chk("out_valid", int'(bus.out_valid), m_ov);
    chk("dir_up",    int'(bus.dir_up),    m_dir);
    chk("step_err",  int'(bus.step_err),  m_serr);
    chk("locked",    int'(bus.locked),    m_locked);
    chk("wrap_cnt",  int'(bus.wrap_cnt),  m_wrap);
  endtask

  // One clock: drive inputs away from the edge, advance model, compare after the edge
  task automatic step(input logic [2:0] g, input bit v, input bit r);
    rst = r;
    bus.G = g[2];
    bus.H = g[1];
    bus.I = g[0];
    bus.in_valid = v;
    model_update(int'(g), v, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    n_checks = 0;
    n_err = 0;
    rst = 1'b1;
    bus.G = 1'b0; bus.H = 1'b0; bus.I = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    step(3'b000, 1'b0, 1'b1);
    step(3'b101, 1'b1, 1'b1);
    chk("reset_locked", int'(bus.locked), 0);
    chk("reset_bin", int'(bus.bin), 0);

    // 1: full upward revolution
    step(3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(gtab[i % 8], 1'b1, 1'b0);
      chk("t1_bin", int'(bus.bin), i % 8);
      if (i >= 1) chk("t1_locked", int'(bus.locked), 1);
    end
    chk("t1_wrap", int'(bus.wrap_cnt), 1);
    chk("t1_dir", int'(bus.dir_up), 1);

    // 2: downward across zero
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    step(3'b100, 1'b1, 1'b0);
    chk("t2_bin7", int'(bus.bin), 7);
    step(3'b101, 1'b1, 1'b0);
    step(3'b111, 1'b1, 1'b0);
    chk("t2_bin5", int'(bus.bin), 5);
    chk("t2_dir", int'(bus.dir_up), 0);
    chk("t2_wrap", int'(bus.wrap_cnt), 255);

    // 3: three illegal jumps force re-acquire
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    step(3'b011, 1'b1, 1'b0);
    chk("t3_err1", int'(bus.step_err), 1);
    chk("t3_lock1", int'(bus.locked), 1);
    step(3'b111, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    chk("t3_err3", int'(bus.step_err), 1);
    chk("t3_unlock", int'(bus.locked), 0);
    step(3'b000, 1'b0, 1'b0);
    chk("t3_err_pulse", int'(bus.step_err), 0);

    // 4: repeated hold samples while locked
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b1, 1'b0);
    step(3'b001, 1'b1, 1'b0);
    step(3'b011, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(3'b011, 1'b1, 1'b0);
      chk("t4_bin", int'(bus.bin), 2);
      chk("t4_err", int'(bus.step_err), 0);
      chk("t4_dir", int'(bus.dir_up), 1);
      chk("t4_wrap", int'(bus.wrap_cnt), 0);
    end

    // 5: idle gap mid-stream
    step(3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(3'b111, 1'b0, 1'b0);
      chk("t5_ov", int'(bus.out_valid), 0);
      chk("t5_bin", int'(bus.bin), 3);
    end
    step(3'b110, 1'b1, 1'b0);
    chk("t5_resume_ov", int'(bus.out_valid), 1);
    chk("t5_resume_bin", int'(bus.bin), 4);

    // 6: reset with a valid sample while locked
    step(3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 25; i++) step(gtab[i % 8], 1'b1, 1'b0);
    chk("t6_wrap3", int'(bus.wrap_cnt), 3);
    step(3'b010, 1'b1, 1'b1);
    chk("t6_rst_wrap", int'(bus.wrap_cnt), 0);
    chk("t6_rst_locked", int'(bus.locked), 0);
    chk("t6_rst_ov", int'(bus.out_valid), 0);
    step(3'b001, 1'b1, 1'b0);
    chk("t6_seed_locked", int'(bus.locked), 0);
    chk("t6_seed_bin", int'(bus.bin), 1);
    step(3'b011, 1'b1, 1'b0);
    chk("t6_relock", int'(bus.locked), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
